core_inst_sequencer: RTL and testbench

Instruction sequencer that drives the 20-bit inst bus and the mem_in bus of the single-core SFP datapath (core/fullchip).
- Accepts a job from the host: col K vectors, then num_q Q vectors, over a valid/ready stream.
- Runs the full load / kernel-load / execute / drain / writeback / readout sequence autonomously.
- Flags when the core's out bus carries a valid psum row.

---
 rtl/core_inst_sequencer_if.sv | 11 +
 rtl/core_inst_sequencer.sv | 157 +++++++++++++++
 tb/tb_core_inst_sequencer.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_inst_sequencer_if.sv
// Host-to-sequencer vector stream: one vector moves on each cycle where valid and ready are both high.
interface core_inst_sequencer_if #(
  parameter int DW = 64
);
  logic [DW-1:0] host_data;
  logic          host_valid;
  logic          host_ready;

  modport master (output host_data, output host_valid, input host_ready);
  modport slave  (input host_data, input host_valid, output host_ready);
endinterface

// File: rtl/core_inst_sequencer.sv
// Drives inst/mem_in of the SFP core through load, kernel-load, execute, drain, writeback and readout for one job.
// inst/mem_in are registered (one cycle after the decision); host stalls only hold the two load phases.
module core_inst_sequencer #(
  parameter int col       = 8,
  parameter int bw        = 8,
  parameter int pr        = 8,
  parameter int addr_w    = 4,
  parameter int drain_lat = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   num_q,
  core_inst_sequencer_if.slave host,
  output logic [19:0]         inst,
  output logic [pr*bw-1:0]    mem_in,
  output logic                busy,
  output logic                done,
  output logic                psum_valid,
  output logic [addr_w-1:0]   psum_idx
);

  localparam int CW_A = (addr_w + 1 > $clog2(col + 1)) ? addr_w + 1 : $clog2(col + 1);
  localparam int CW   = (CW_A > $clog2(drain_lat + 1)) ? CW_A : $clog2(drain_lat + 1);

  localparam int B_OFIFO_RD = 19;
  localparam int B_PMEM_WR  = 18;
  localparam int B_PMEM_RD  = 17;
  localparam int B_QMEM_WR  = 16;
  localparam int B_QMEM_RD  = 15;
  localparam int B_KMEM_WR  = 14;
  localparam int B_KMEM_RD  = 13;
  localparam int B_LOAD     = 12;
  localparam int B_EXECUTE  = 11;

  typedef enum logic [3:0] {
    IDLE, LD_K, LD_Q, KLOAD, EXEC, DRAIN, WB, RD, FIN
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] nq;
  logic [19:0]   inst_nxt;
  logic          mem_we;
  logic [3:0]    addr4;
  logic          last_k, last_q, last_d;

  // nq is one wider than addr_w so a count of 2^addr_w reaches its terminal compare
  assign addr4  = 4'(cnt[addr_w-1:0]);
  assign last_k = (cnt == CW'(col - 1));
  assign last_q = (cnt == nq - CW'(1));
  assign last_d = (cnt == CW'(drain_lat - 1));

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + CW'(1);
    inst_nxt        = '0;
    mem_we          = 1'b0;
    host.host_ready = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = LD_K;
      end
      LD_K, LD_Q: begin
        host.host_ready = 1'b1;
        cnt_nxt         = cnt;
        if (host.host_valid) begin
          if (state == LD_K) inst_nxt[B_KMEM_WR] = 1'b1;
          else               inst_nxt[B_QMEM_WR] = 1'b1;
          inst_nxt[3:0] = addr4;
          mem_we        = 1'b1;
          cnt_nxt       = cnt + CW'(1);
          if ((state == LD_K) ? last_k : last_q) begin
            cnt_nxt   = '0;
            state_nxt = (state == LD_K) ? LD_Q : KLOAD;
          end
        end
      end
      KLOAD: begin
        inst_nxt[B_KMEM_RD] = 1'b1;
        inst_nxt[B_LOAD]    = 1'b1;
        inst_nxt[3:0]       = addr4;
        if (last_k) begin
          cnt_nxt   = '0;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        inst_nxt[B_QMEM_RD] = 1'b1;
        inst_nxt[B_EXECUTE] = 1'b1;
        inst_nxt[3:0]       = addr4;
        if (last_q) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_d) begin
          cnt_nxt   = '0;
          state_nxt = WB;
        end
      end
      WB: begin
        inst_nxt[B_OFIFO_RD] = 1'b1;
        inst_nxt[B_PMEM_WR]  = 1'b1;
        inst_nxt[3:0]        = addr4;
        if (last_q) begin
          cnt_nxt   = '0;
          state_nxt = RD;
        end
      end
      RD: begin
        inst_nxt[B_PMEM_RD] = 1'b1;
        inst_nxt[3:0]       = addr4;
        if (last_q) begin
          cnt_nxt   = '0;
          state_nxt = FIN;
        end
      end
      FIN: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      nq         <= '0;
      inst       <= '0;
      mem_in     <= '0;
      psum_valid <= 1'b0;
      psum_idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      inst  <= inst_nxt;
      if (mem_we) mem_in <= host.host_data;
      if (state == IDLE && start)
        nq <= (num_q == '0) ? CW'(2 ** addr_w) : CW'(num_q);
      // psum for a pmem_rd is on the core out bus one cycle after the read issues
      psum_valid <= inst[B_PMEM_RD];
      if (inst[B_PMEM_RD]) psum_idx <= addr_w'(inst[3:0]);
    end
  end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench: random host vectors and stall patterns checked against a per-job list of expected core instructions.
module tb_core_inst_sequencer;

  localparam int COL   = 8;
  localparam int DRAIN = 10;

  localparam logic [19:0] I_KWR = 20'h04000;
  localparam logic [19:0] I_QWR = 20'h10000;
  localparam logic [19:0] I_KLD = 20'h03000;
  localparam logic [19:0] I_EXE = 20'h08800;
  localparam logic [19:0] I_WB  = 20'hC0000;
  localparam logic [19:0] I_RD  = 20'h20000;

  typedef struct {
    logic [19:0] inst;
    logic [63:0] data;
    bit          wr;
  } ev_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_q;
  logic [19:0] inst;
  logic [63:0] mem_in;
  logic        busy, done, psum_valid;
  logic [3:0]  psum_idx;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_mem;

  core_inst_sequencer_if #(.DW(64)) hif ();

  core_inst_sequencer #(
    .col(COL), .bw(8), .pr(8), .addr_w(4), .drain_lat(DRAIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_q      (num_q),
    .host       (hif.slave),
    .inst       (inst),
    .mem_in     (mem_in),
    .busy       (busy),
    .done       (done),
    .psum_valid (psum_valid),
    .psum_idx   (psum_idx)
  );

  always #5 clk = ~clk;

  function automatic ev_t mk(input logic [19:0] i, input logic [63:0] d, input bit w);
    ev_t e;
    e.inst = i;
    e.data = d;
    e.wr   = w;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // mode: 0 = host always valid, 1 = valid every other cycle, 2 = random valid
  task automatic run_job(input int nq_in, input int mode, input bit glitch, input string tag);
    ev_t         exp_q[$];
    int          pidx[$];
    logic [63:0] vec[$];
    logic [63:0] xdat_prev;
    logic [19:0] want;
    int          nq, n, idx, stalls, done_n, last_exe, first_wb, last_ps;
    bit          xfer_prev, vld, g_exec, finished;

    nq = (nq_in == 0) ? 16 : nq_in;
    for (int i = 0; i < COL + nq; i++) vec.push_back(rnd64());
    for (int i = 0; i < COL; i++) exp_q.push_back(mk(I_KWR | 20'(i), vec[i], 1'b1));
    for (int i = 0; i < nq; i++)  exp_q.push_back(mk(I_QWR | 20'(i), vec[COL + i], 1'b1));
    for (int i = 0; i < COL; i++) exp_q.push_back(mk(I_KLD | 20'(i), '0, 1'b0));
    for (int i = 0; i < nq; i++)  exp_q.push_back(mk(I_EXE | 20'(i), '0, 1'b0));
    for (int i = 0; i < nq; i++)  exp_q.push_back(mk(I_WB  | 20'(i), '0, 1'b0));
    for (int i = 0; i < nq; i++)  exp_q.push_back(mk(I_RD  | 20'(i), '0, 1'b0));
    for (int i = 0; i < nq; i++)  pidx.push_back(i);

    @(negedge clk);
    start = 1'b1;
    num_q = 4'(nq_in);
    hif.host_valid = 1'b0;
    xfer_prev = 1'b0; xdat_prev = '0; idx = 0; stalls = 0;
    done_n = -1; last_exe = -1; first_wb = -1; last_ps = -1;
    g_exec = 1'b0; finished = 1'b0;

    for (n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      if (xfer_prev) exp_mem = xdat_prev;
      n_cmp++;
      if (mem_in !== exp_mem) begin
        n_err++;
        $display("FAIL %s mem_in n=%0d: got %h want %h", tag, n, mem_in, exp_mem);
      end
      if (exp_q.size() > 0 && exp_q[0].wr) begin
        want = xfer_prev ? exp_q[0].inst : 20'h0;
        n_cmp++;
        if (inst !== want) begin
          n_err++;
          $display("FAIL %s load_inst n=%0d: got %h want %h", tag, n, inst, want);
        end
        if (xfer_prev) void'(exp_q.pop_front());
      end else if (inst !== 20'h0) begin
        n_cmp++;
        if (exp_q.size() == 0 || inst !== exp_q[0].inst) begin
          n_err++;
          $display("FAIL %s inst_order n=%0d: got %h want %h", tag, n, inst,
                   (exp_q.size() > 0) ? exp_q[0].inst : 20'h0);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (inst[11]) last_exe = n;
      if (inst[19] && first_wb < 0) first_wb = n;
      if (psum_valid) begin
        n_cmp++;
        if (pidx.size() == 0 || psum_idx !== 4'(pidx[0])) begin
          n_err++;
          $display("FAIL %s psum_idx n=%0d: got %0d want %0d", tag, n, psum_idx,
                   (pidx.size() > 0) ? pidx[0] : -1);
        end
        if (pidx.size() > 0) void'(pidx.pop_front());
        last_ps = n;
      end
      if (done_n < 0) begin
        if (done === 1'b1) done_n = n;
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy n=%0d: got %b want 1", tag, n, busy);
        end
      end else begin
        n_cmp++;
        if ({done, busy, hif.host_ready} !== 3'b000) begin
          n_err++;
          $display("FAIL %s after_done {done,busy,ready}: got %b want 000", tag,
                   {done, busy, hif.host_ready});
        end
        finished = 1'b1;
        break;
      end
      @(negedge clk);
      start = glitch && ((inst[11] && !g_exec) || n == done_n);
      if (inst[11]) g_exec = 1'b1;
      vld = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 2 == 1) : 1'($urandom_range(0, 1));
      hif.host_valid = vld;
      hif.host_data  = (idx < vec.size()) ? vec[idx] : rnd64();
      n_cmp++;
      if (hif.host_ready !== (idx < COL + nq)) begin
        n_err++;
        $display("FAIL %s host_ready n=%0d: got %b want %b", tag, n, hif.host_ready, idx < COL + nq);
      end
      if (hif.host_ready && !vld) stalls++;
      xfer_prev = vld && hif.host_ready;
      xdat_prev = hif.host_data;
      if (xfer_prev) idx++;
    end
    start = 1'b0;
    hif.host_valid = 1'b0;

    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL %s timeout: got no done within 600 cycles, want done", tag);
    end else begin
      if (done_n !== 2 * COL + 4 * nq + DRAIN + stalls) begin
        n_err++;
        $display("FAIL %s done_latency: got %0d want %0d", tag, done_n + 2,
                 2 * COL + 4 * nq + DRAIN + stalls + 2);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_err++;
        $display("FAIL %s inst_left: got %0d unissued want 0", tag, exp_q.size());
      end
      n_cmp++;
      if (pidx.size() != 0) begin
        n_err++;
        $display("FAIL %s psum_left: got %0d missing want 0", tag, pidx.size());
      end
      n_cmp++;
      if (last_ps !== done_n + 1) begin
        n_err++;
        $display("FAIL %s last_psum: got n=%0d want n=%0d", tag, last_ps, done_n + 1);
      end
      n_cmp++;
      if (first_wb - last_exe !== DRAIN + 1) begin
        n_err++;
        $display("FAIL %s drain_gap: got %0d want %0d", tag, first_wb - last_exe, DRAIN + 1);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({inst, mem_in, busy, done, psum_valid, psum_idx, hif.host_ready} !== '0) begin
        n_err++;
        $display("FAIL reset_idle c=%0d: got inst=%h mem_in=%h busy=%b done=%b pv=%b pi=%0d rdy=%b want all 0",
                 i, inst, mem_in, busy, done, psum_valid, psum_idx, hif.host_ready);
      end
    end
  endtask

  task automatic test_full_job();
    run_job(8, 0, 1'b0, "full");
  endtask

  task automatic test_host_stalls();
    run_job(8, 1, 1'b0, "stall");
  endtask

  task automatic test_nq_zero();
    run_job(0, 2, 1'b0, "nq0");
  endtask

  task automatic test_back_to_back();
    run_job(8, 0, 1'b1, "ign_start");
    run_job(5, 0, 1'b0, "b2b");
  endtask

  task automatic test_reset_mid_exec();
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1; num_q = 4'd8;
    hif.host_valid = 1'b1; hif.host_data = rnd64();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (inst[11]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      start = 1'b0;
      hif.host_data = rnd64();
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b1; hif.host_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (!seen || {inst, mem_in, busy, done, psum_valid, hif.host_ready} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_exec: seen_exec=%b got inst=%h mem_in=%h busy=%b done=%b pv=%b rdy=%b want all 0",
               seen, inst, mem_in, busy, done, psum_valid, hif.host_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_mem = '0;
    run_job(8, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) run_job(int'($urandom_range(0, 15)), 2, 1'b0, "rand");
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    num_q = '0;
    hif.host_valid = 1'b0;
    hif.host_data  = '0;
    exp_mem = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_full_job();
    test_host_stalls();
    test_nq_zero();
    test_back_to_back();
    test_reset_mid_exec();
    test_random_jobs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
